// File: rtl/twin_channel_merge_if.sv
// Bundle of the two input channels, the merged output stream and the fill levels
// for twin_channel_merge. The "master" side drives the inputs; "slave" is the merger.
interface twin_channel_merge_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in2_data;
    logic             in2_valid;
    logic             in2_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_chan;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    fill1;
    logic [CW-1:0]    fill2;

    modport master (
        output in1_data, in1_valid, in2_data, in2_valid, out_ready,
        input  in1_ready, in2_ready, out_data, out_chan, out_valid, fill1, fill2
    );

    modport slave (
        input  in1_data, in1_valid, in2_data, in2_valid, out_ready,
        output in1_ready, in2_ready, out_data, out_chan, out_valid, fill1, fill2
    );
endinterface

// File: rtl/twin_channel_merge.sv
// Two per-channel FIFOs merged round-robin into one registered, channel-tagged stream.
// The output register doubles as the registered read port of both FIFO memories.
module twin_channel_merge #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    twin_channel_merge_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] in_data [2];
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0]       nonempty;
    logic [1:0]       pop;
    logic [WIDTH-1:0] head [2];
    logic [CW-1:0]    fill [2];

    logic             load;
    logic             grant;
    logic             out_valid_reg;
    logic             out_chan_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             last_grant_reg;

    assign in_data[0]  = bus.in1_data;
    assign in_data[1]  = bus.in2_data;
    assign in_valid[0] = bus.in1_valid;
    assign in_valid[1] = bus.in2_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]    wr_ptr_reg;
            logic [AW-1:0]    rd_ptr_reg;
            logic [CW-1:0]    fill_reg;
            logic             push;

            // Ready depends only on occupancy: a full FIFO never accepts, even while popping.
            assign in_ready[gi] = (fill_reg != CW'(DEPTH));
            assign push         = in_valid[gi] && in_ready[gi];
            assign nonempty[gi] = (fill_reg != '0);
            assign head[gi]     = mem[rd_ptr_reg];
            assign fill[gi]     = fill_reg;

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= in_data[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    fill_reg   <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    end
                    case ({push, pop[gi]})
                        2'b10:   fill_reg <= fill_reg + CW'(1);
                        2'b01:   fill_reg <= fill_reg - CW'(1);
                        default: fill_reg <= fill_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Arbitration sees only pre-edge FIFO state, so a same-edge push is never eligible.
    always_comb begin
        load  = !out_valid_reg || bus.out_ready;
        grant = 1'b0;
        pop   = '0;
        if (nonempty == 2'b11) begin
            grant = !last_grant_reg;
        end else if (nonempty[1]) begin
            grant = 1'b1;
        end
        if (load && (nonempty != '0)) begin
            pop = grant ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_chan_reg   <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (load) begin
            if (nonempty != '0) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= head[grant];
                out_chan_reg   <= grant;
                last_grant_reg <= grant;
            end else begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign bus.in1_ready = in_ready[0];
    assign bus.in2_ready = in_ready[1];
    assign bus.out_data  = out_data_reg;
    assign bus.out_chan  = out_chan_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.fill1     = fill[0];
    assign bus.fill2     = fill[1];
endmodule

// File: tb/tb_twin_channel_merge.sv
// Directed bench for twin_channel_merge: reset, latency, contention, backpressure,
// full-FIFO push/pop and boundary data, each against hand-computed expectations.
module tb_twin_channel_merge;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    twin_channel_merge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    twin_channel_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] exp_data [$];
    logic       exp_chan [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [7:0] d, input logic c);
        exp_data.push_back(d);
        exp_chan.push_back(c);
    endtask

    // Drives queued words on both channels, scores every output handshake in order.
    task automatic run_cycles(input int n);
        logic acc1, acc2;
        for (int i = 0; i < n; i++) begin
            bus.in1_valid = (q1.size() > 0);
            bus.in1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
            bus.in2_valid = (q2.size() > 0);
            bus.in2_data  = (q2.size() > 0) ? q2[0] : 8'h00;
            acc1 = bus.in1_valid && bus.in1_ready;
            acc2 = bus.in2_valid && bus.in2_ready;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_data.size() == 0) begin
                    check_eq("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    check_eq("out_data", 32'(bus.out_data), 32'(exp_data[0]));
                    check_eq("out_chan", 32'(bus.out_chan), 32'(exp_chan[0]));
                    void'(exp_data.pop_front());
                    void'(exp_chan.pop_front());
                end
            end
            step();
            if (acc1) void'(q1.pop_front());
            if (acc2) void'(q2.pop_front());
        end
        bus.in1_valid = 1'b0;
        bus.in2_valid = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check_eq(tag, 32'(exp_data.size()), 32'd0);
        exp_data.delete();
        exp_chan.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in1_data  = '0;
        bus.in1_valid = 1'b0;
        bus.in2_data  = '0;
        bus.in2_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_out_chan", 32'(bus.out_chan), 32'd0);
        check_eq("rst_fill1", 32'(bus.fill1), 32'd0);
        check_eq("rst_fill2", 32'(bus.fill2), 32'd0);
        step();
        rst = 1'b0;
        step();
        check_eq("rst_in1_ready", 32'(bus.in1_ready), 32'd1);
        check_eq("rst_in2_ready", 32'(bus.in2_ready), 32'd1);

        // 1: buffer three words, then reset mid-cycle
        bus.in1_valid = 1'b1; bus.in1_data = 8'hA1;
        bus.in2_valid = 1'b1; bus.in2_data = 8'hB1;
        step();
        bus.in2_valid = 1'b0; bus.in1_data = 8'hA2;
        step();
        bus.in1_valid = 1'b0;
        check_eq("t1_pre_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t1_pre_out_data", 32'(bus.out_data), 32'hA1);
        check_eq("t1_pre_fill1", 32'(bus.fill1), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t1_async_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t1_async_fill1", 32'(bus.fill1), 32'd0);
        check_eq("t1_async_fill2", 32'(bus.fill2), 32'd0);
        step();
        #3;
        rst = 1'b0;
        step();
        bus.out_ready = 1'b1;
        q1.push_back(8'd52);
        q2.push_back(8'd45);
        expect_word(8'd52, 1'b0);
        expect_word(8'd45, 1'b1);
        run_cycles(5);
        check_drained("t1_drained");

        // 2: single channel, one-cycle latency, fill1 peaks at 1
        bus.in1_valid = 1'b1; bus.in1_data = 8'd11;
        step();
        check_eq("t2_n_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t2_n_fill1", 32'(bus.fill1), 32'd1);
        bus.in1_data = 8'd36;
        step();
        check_eq("t2_n1_out_data", 32'(bus.out_data), 32'd11);
        check_eq("t2_n1_out_chan", 32'(bus.out_chan), 32'd0);
        check_eq("t2_n1_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t2_n1_fill1", 32'(bus.fill1), 32'd1);
        bus.in1_data = 8'd63;
        step();
        check_eq("t2_n2_out_data", 32'(bus.out_data), 32'd36);
        check_eq("t2_n2_fill1", 32'(bus.fill1), 32'd1);
        bus.in1_valid = 1'b0;
        step();
        check_eq("t2_n3_out_data", 32'(bus.out_data), 32'd63);
        check_eq("t2_n3_fill1", 32'(bus.fill1), 32'd0);
        step();
        check_eq("t2_idle_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t2_idle_out_data_hold", 32'(bus.out_data), 32'd63);

        // 3: one ch2 word hands the next contention to ch1, then alternate
        q2.push_back(8'd77);
        expect_word(8'd77, 1'b1);
        run_cycles(4);
        check_drained("t3_pre_drained");
        for (int i = 1; i <= 4; i++) begin
            q1.push_back(8'(i));
            q2.push_back(8'(100 + i));
            expect_word(8'(i), 1'b0);
            expect_word(8'(100 + i), 1'b1);
        end
        run_cycles(14);
        check_drained("t3_drained");

        // 4: backpressure fills ch2; the output register holds the first word
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) q2.push_back(8'(200 + i));
        run_cycles(9);
        check_eq("t4_fill2", 32'(bus.fill2), 32'd4);
        check_eq("t4_in2_ready", 32'(bus.in2_ready), 32'd0);
        check_eq("t4_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t4_out_data_hold", 32'(bus.out_data), 32'd201);
        check_eq("t4_not_accepted", 32'(q2.size()), 32'd1);
        q2.delete();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) expect_word(8'(200 + i), 1'b1);
        run_cycles(8);
        check_drained("t4_drained");
        check_eq("t4_fill2_empty", 32'(bus.fill2), 32'd0);

        // 5: full ch1 with push attempted while popping
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) q1.push_back(8'(i));
        run_cycles(7);
        check_eq("t5_fill1_full", 32'(bus.fill1), 32'd4);
        check_eq("t5_in1_ready_low", 32'(bus.in1_ready), 32'd0);
        bus.out_ready = 1'b1;
        bus.in1_valid = 1'b1; bus.in1_data = 8'd6;
        step();
        check_eq("t5_e1_fill1", 32'(bus.fill1), 32'd3);
        check_eq("t5_e1_out_data", 32'(bus.out_data), 32'd2);
        check_eq("t5_e1_in1_ready", 32'(bus.in1_ready), 32'd1);
        step();
        check_eq("t5_e2_fill1", 32'(bus.fill1), 32'd3);
        check_eq("t5_e2_out_data", 32'(bus.out_data), 32'd3);
        bus.in1_valid = 1'b0;
        for (int i = 3; i <= 6; i++) expect_word(8'(i), 1'b0);
        run_cycles(7);
        check_drained("t5_drained");

        // 6: boundary values, then contention after a ch1 grant goes to ch2
        q2.push_back(8'hFF);
        run_cycles(1);
        q1.push_back(8'h00);
        expect_word(8'hFF, 1'b1);
        expect_word(8'h00, 1'b0);
        run_cycles(5);
        check_drained("t6_boundary_drained");
        q1.push_back(8'h11);
        q2.push_back(8'h22);
        expect_word(8'h22, 1'b1);
        expect_word(8'h11, 1'b0);
        run_cycles(5);
        check_drained("t6_contention_drained");
        check_eq("t6_final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
